// File: rtl/rob_commit.sv
// Eight-entry reorder buffer: allocates tags at issue, accepts write-backs by tag,
// and retires the oldest completed entry per cycle toward the register bank.
module rob_commit #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned RW    = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          alloc_valid,
   input  logic [RW-1:0] alloc_rd,
   output logic          alloc_ready,
   output logic [2:0]    alloc_tag,
   input  logic          wb_valid,
   input  logic [2:0]    wb_tag,
   input  logic [DW-1:0] wb_data,
   input  logic          commit_stall,
   output logic          commit_valid,
   output logic [2:0]    commit_tag,
   output logic [RW-1:0] commit_rd,
   output logic [DW-1:0] commit_data,
   output logic [3:0]    count,
   output logic          empty,
   output logic          full,
   output logic          wb_err
);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [RW-1:0]    rd_q   [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [2:0]       head_q, head_d;
   logic [2:0]       tail_q, tail_d;
   logic [3:0]       count_q, count_d;
   logic             commit_valid_q;
   logic [2:0]       commit_tag_q;
   logic [RW-1:0]    commit_rd_q;
   logic [DW-1:0]    commit_data_q;
   logic             wb_err_q, wb_err_d;

   logic alloc_fire, wb_hit, retire;

   assign full        = (count_q == 4'd8);
   assign empty       = (count_q == 4'd0);
   assign alloc_ready = ~full;
   assign alloc_tag   = tail_q;
   assign count       = count_q;

   assign alloc_fire = alloc_valid & ~full;
   assign wb_hit     = wb_valid & busy_q[wb_tag] & ~done_q[wb_tag];
   // Retire only looks at entries already done, so it never races a same-edge write-back.
   assign retire     = busy_q[head_q] & done_q[head_q] & ~commit_stall;

   always_comb begin
      busy_d   = busy_q;
      done_d   = done_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      wb_err_d = wb_err_q;
      if (retire) begin
         busy_d[head_q] = 1'b0;
         done_d[head_q] = 1'b0;
         head_d         = head_q + 3'd1;
      end
      if (alloc_fire) begin
         busy_d[tail_q] = 1'b1;
         done_d[tail_q] = 1'b0;
         tail_d         = tail_q + 3'd1;
      end
      if (wb_hit) begin
         done_d[wb_tag] = 1'b1;
      end else if (wb_valid) begin
         wb_err_d = 1'b1;
      end
      unique case ({alloc_fire, retire})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         busy_q         <= '0;
         done_q         <= '0;
         head_q         <= 3'd0;
         tail_q         <= 3'd0;
         count_q        <= 4'd0;
         wb_err_q       <= 1'b0;
         commit_valid_q <= 1'b0;
         commit_tag_q   <= 3'd0;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
      end else begin
         busy_q         <= busy_d;
         done_q         <= done_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         wb_err_q       <= wb_err_d;
         commit_valid_q <= retire;
         if (retire) begin
            commit_tag_q  <= head_q;
            commit_rd_q   <= rd_q[head_q];
            commit_data_q <= data_q[head_q];
         end
      end
   end

   // Payload storage needs no reset: busy/done gate every use of it.
   always_ff @(posedge clk1) begin
      if (alloc_fire) rd_q[tail_q] <= alloc_rd;
      if (wb_hit)     data_q[wb_tag] <= wb_data;
   end

   assign commit_valid = commit_valid_q;
   assign commit_tag   = commit_tag_q;
   assign commit_rd    = commit_rd_q;
   assign commit_data  = commit_data_q;
   assign wb_err       = wb_err_q;

endmodule
